seq_dfa_detector: RTL and testbench

Parametrised serial pattern-detecting DFA, the next generation of the team's fixed `dfa` block.
- Consumes one bit per valid beat.
- Tracks the longest matched prefix of a configurable pattern using KMP-style fallback transitions.
- Emits a registered match pulse and keeps a saturating match counter.
- Sits behind a serial deserialiser / bit source; `testbench` drives it directly.

---
 rtl/dfa_pkg.sv | 53 +++++
 rtl/seq_dfa_next.sv | 36 +++
 rtl/seq_dfa_detector.sv | 58 +++++
 tb/tb_seq_dfa_detector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfa_pkg.sv
// Shared elaboration-time helpers for the serial pattern DFA: state width and
// KMP border / transition functions evaluated over a constant pattern.
package dfa_pkg;

    localparam int unsigned MAX_PATTERN_W = 16;

    function automatic int unsigned dfa_state_w(input int unsigned width);
        return $clog2(width);
    endfunction

    // Longest proper border of the first k pattern bits (pattern MSB-first in width bits).
    function automatic int dfa_fail(input logic [15:0] pattern, input int width, input int k);
        int  len;
        logic ok;
        len = 0;
        for (int j = MAX_PATTERN_W - 1; j >= 1; j--) begin
            if (len == 0 && j < k) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PATTERN_W; i++) begin
                    if (i < j && pattern[4'(width - 1 - (k - j + i))] != pattern[4'(width - 1 - i)])
                        ok = 1'b0;
                end
                if (ok) len = j;
            end
        end
        return len;
    endfunction

    // Length of the longest pattern prefix that is a suffix of (prefix_k, b).
    function automatic int dfa_next(input logic [15:0] pattern, input int width, input int k,
                                    input logic b);
        int   len;
        int   t;
        logic ok;
        logic sb;
        len = 0;
        for (int j = MAX_PATTERN_W; j >= 1; j--) begin
            if (len == 0 && j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PATTERN_W; i++) begin
                    if (i < j) begin
                        t  = k + 1 - j + i;
                        sb = (t == k) ? b : pattern[4'(width - 1 - t)];
                        if (sb != pattern[4'(width - 1 - i)]) ok = 1'b0;
                    end
                end
                if (ok) len = j;
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_dfa_next.sv
// Combinational DFA transition: (matched prefix length, bit) -> next prefix
// length and full-match flag, from tables built at elaboration.
module seq_dfa_next
    import dfa_pkg::*;
#(
    parameter int unsigned            PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]   PATTERN   = 4'b1011,
    localparam int unsigned           STATE_W   = dfa_state_w(PATTERN_W),
    localparam int unsigned           LEN_W     = STATE_W + 1
) (
    input  logic [STATE_W-1:0] state,
    input  logic               in_bit,
    output logic [LEN_W-1:0]   next_len,
    output logic               full
);

    localparam int unsigned ROWS = 1 << STATE_W;

    logic [LEN_W-1:0] table_0 [ROWS];
    logic [LEN_W-1:0] table_1 [ROWS];

    // Rows at or above PATTERN_W are unreachable encodings and fall back to 0.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        if (k < PATTERN_W) begin : g_live
            assign table_0[k] = LEN_W'(dfa_next(16'(PATTERN), int'(PATTERN_W), k, 1'b0));
            assign table_1[k] = LEN_W'(dfa_next(16'(PATTERN), int'(PATTERN_W), k, 1'b1));
        end else begin : g_dead
            assign table_0[k] = '0;
            assign table_1[k] = '0;
        end
    end

    assign next_len = in_bit ? table_1[state] : table_0[state];
    assign full     = (next_len == LEN_W'(PATTERN_W));

endmodule

// File: rtl/seq_dfa_detector.sv
// Serial pattern detector: KMP-style DFA over valid beats with a registered
// match pulse and a saturating, clearable match counter.
module seq_dfa_detector
    import dfa_pkg::*;
#(
    parameter int unsigned            PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]   PATTERN   = 4'b1011,
    parameter bit                     OVERLAP   = 1'b1,
    parameter int unsigned            COUNT_W   = 8,
    localparam int unsigned           STATE_W   = dfa_state_w(PATTERN_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned LEN_W = STATE_W + 1;

    // Where the DFA resumes after a full match.
    localparam logic [STATE_W-1:0] RESTART =
        OVERLAP ? STATE_W'(dfa_fail(16'(PATTERN), int'(PATTERN_W), int'(PATTERN_W))) : '0;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [LEN_W-1:0] next_len;
    logic             full;

    seq_dfa_next #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN)
    ) u_next (
        .state    (state),
        .in_bit   (in_bit),
        .next_len (next_len),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= in_valid & full;
            if (in_valid) state <= full ? RESTART : STATE_W'(next_len);
            // Clear wins over a coincident increment; the pulse above is unaffected.
            if (count_clr)
                match_count <= '0;
            else if (in_valid && full && match_count != COUNT_MAX)
                match_count <= match_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_dfa_detector.sv
// Bench for seq_dfa_detector: several parameterisations share one input stream
// and are checked against scripted expectations and a history-based model.
module tb_seq_dfa_detector;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst, in_valid, in_bit, count_clr;
    always #5 clk = ~clk;

    logic       m0, m1, m2, m3, m4;
    logic [7:0] c0, c1, c3, c4;
    logic [1:0] c2;
    logic [1:0] s0, s1, s2, s3;
    logic [2:0] s4;

    seq_dfa_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .count_clr(count_clr),
        .match(m0), .match_count(c0), .state(s0));
    seq_dfa_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .count_clr(count_clr),
        .match(m1), .match_count(c1), .state(s1));
    seq_dfa_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .count_clr(count_clr),
        .match(m2), .match_count(c2), .state(s2));
    seq_dfa_detector #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .COUNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .count_clr(count_clr),
        .match(m3), .match_count(c3), .state(s3));
    seq_dfa_detector #(.PATTERN_W(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .COUNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .count_clr(count_clr),
        .match(m4), .match_count(c4), .state(s4));

    logic       m_o [N];
    logic [7:0] c_o [N];
    logic [3:0] s_o [N];
    assign m_o[0] = m0; assign c_o[0] = c0;     assign s_o[0] = 4'(s0);
    assign m_o[1] = m1; assign c_o[1] = c1;     assign s_o[1] = 4'(s1);
    assign m_o[2] = m2; assign c_o[2] = 8'(c2); assign s_o[2] = 4'(s2);
    assign m_o[3] = m3; assign c_o[3] = c3;     assign s_o[3] = 4'(s3);
    assign m_o[4] = m4; assign c_o[4] = c4;     assign s_o[4] = 4'(s4);

    // Model configuration mirrors the instance parameters above.
    int          pw [N] = '{4, 4, 4, 3, 6};
    logic [15:0] pp [N] = '{16'hB, 16'hB, 16'hB, 16'h7, 16'h36};
    bit          ov [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int          cw [N] = '{8, 8, 2, 8, 8};

    // Model: raw bit history (newest in bit 0) since reset or last non-overlap match.
    logic [63:0] hist [N];
    int          hlen [N];
    logic        em   [N];
    int          ec   [N];
    int          es   [N];

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] low_mask(input int k);
        return (64'd1 << k) - 64'd1;
    endfunction

    function automatic int longest_prefix(input int d);
        for (int k = pw[d] - 1; k >= 1; k--) begin
            if (k <= hlen[d] && (hist[d] & low_mask(k)) == (64'(pp[d]) >> (pw[d] - k)))
                return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            hist[d] = '0; hlen[d] = 0; em[d] = 1'b0; ec[d] = 0; es[d] = 0;
        end
    endtask

    task automatic model_beat(input logic v, input logic b, input logic clr);
        for (int d = 0; d < N; d++) begin
            em[d] = 1'b0;
            if (v) begin
                hist[d] = {hist[d][62:0], b};
                if (hlen[d] < 64) hlen[d]++;
                if (hlen[d] >= pw[d] && (hist[d] & low_mask(pw[d])) == 64'(pp[d])) begin
                    em[d] = 1'b1;
                    if (ec[d] < (1 << cw[d]) - 1) ec[d]++;
                    if (!ov[d]) hlen[d] = 0;
                end
                es[d] = longest_prefix(d);
            end
            if (clr) ec[d] = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic b, input logic clr);
        rst = r; in_valid = v; in_bit = b; count_clr = clr;
        @(posedge clk);
        if (r) model_reset();
        else   model_beat(v, b, clr);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (m_o[d] !== 1'b0 || c_o[d] !== 8'd0 || s_o[d] !== 4'd0) begin
                errors++;
                $display("FAIL reset dut%0d: match=%b count=%0d state=%0d, want 0/0/0",
                         d, m_o[d], c_o[d], s_o[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        logic [3:0] want_m;
        int         want_s [4] = '{1, 2, 3, 1};
        bits   = 4'b1011;
        want_m = 4'b0001;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, bits[3 - i], 1'b0);
            checks++;
            if (m0 !== want_m[3 - i] || s_o[0] !== 4'(want_s[i])) begin
                errors++;
                $display("FAIL basic beat%0d: match=%b state=%0d, want %b/%0d",
                         i + 1, m0, s_o[0], want_m[3 - i], want_s[i]);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (m0 !== 1'b0 || c0 !== 8'd1) begin
            errors++;
            $display("FAIL basic after: match=%b count=%0d, want 0/1", m0, c0);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        int         hits0, hits1;
        bits = 7'b1011011;
        hits0 = 0; hits1 = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, bits[6 - i], 1'b0);
            if (m0) hits0 = hits0 * 10 + i + 1;
            if (m1) hits1 = hits1 * 10 + i + 1;
        end
        checks++;
        if (hits0 !== 47 || c0 !== 8'd2) begin
            errors++;
            $display("FAIL overlap1: match beats=%0d count=%0d, want 47/2", hits0, c0);
        end
        checks++;
        if (hits1 !== 4 || c1 !== 8'd1) begin
            errors++;
            $display("FAIL overlap0: match beats=%0d count=%0d, want 4/1", hits1, c1);
        end
    endtask

    task automatic test_fallback();
        logic [4:0] bits;
        int         want_s [5] = '{1, 1, 2, 3, 1};
        bits = 5'b11011;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, bits[4 - i], 1'b0);
            checks++;
            if (m0 !== (i == 4) || s_o[0] !== 4'(want_s[i])) begin
                errors++;
                $display("FAIL fallback beat%0d: match=%b state=%0d, want %b/%0d",
                         i + 1, m0, s_o[0], (i == 4), want_s[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [8:0] vld;
        logic [8:0] bits;
        int         want_s [9] = '{1, 1, 2, 2, 2, 3, 3, 1, 1};
        logic [8:0] want_m;
        vld    = 9'b101001010;
        bits   = 9'b100001010;
        want_m = 9'b000000010;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, vld[8 - i], bits[8 - i], 1'b0);
            checks++;
            if (m0 !== want_m[8 - i] || s_o[0] !== 4'(want_s[i])) begin
                errors++;
                $display("FAIL gaps step%0d: match=%b state=%0d, want %b/%0d",
                         i, m0, s_o[0], want_m[8 - i], want_s[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] bits;
        bits = 4'b1011;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, bits[3 - i], 1'b0);
            checks++;
            if (m2 !== 1'b1 || c2 !== 2'(n < 3 ? n + 1 : 3)) begin
                errors++;
                $display("FAIL sat match%0d: match=%b count=%0d, want 1/%0d",
                         n + 1, m2, c2, (n < 3 ? n + 1 : 3));
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (c2 !== 2'd3 || c0 !== 8'd5) begin
            errors++;
            $display("FAIL sat hold: count2=%0d count0=%0d, want 3/5", c2, c0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, bits[3 - i], 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (m2 !== 1'b1 || c2 !== 2'd0 || c0 !== 8'd0) begin
            errors++;
            $display("FAIL clr vs match: match=%b count2=%0d count0=%0d, want 1/0/0", m2, c2, c0);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (m0 !== 1'b0 || c0 !== 8'd0 || s_o[0] !== 4'd0) begin
            errors++;
            $display("FAIL reset mid: match=%b count=%0d state=%0d, want 0/0/0", m0, c0, s_o[0]);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (m0 !== 1'b0 || s_o[0] !== 4'd1) begin
            errors++;
            $display("FAIL after reset: match=%b state=%0d, want 0/1", m0, s_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (m3 !== (i >= 2)) begin
                errors++;
                $display("FAIL b2b beat%0d: match=%b, want %b", i + 1, m3, (i >= 2));
            end
        end
        checks++;
        if (c3 !== 8'd3 || s_o[3] !== 4'd2) begin
            errors++;
            $display("FAIL b2b end: count=%0d state=%0d, want 3/2", c3, s_o[3]);
        end
    endtask

    task automatic test_random();
        logic r, v, b, clr;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 3000; t++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 9) < 7);
            b   = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 79) == 0);
            cycle(r, v, b, clr);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (m_o[d] !== em[d] || c_o[d] !== 8'(ec[d]) || s_o[d] !== 4'(es[d])) begin
                    errors++;
                    $display("FAIL random t%0d dut%0d: match=%b count=%0d state=%0d, want %b/%0d/%0d",
                             t, d, m_o[d], c_o[d], s_o[d], em[d], ec[d], es[d]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; count_clr = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_overlap();
        test_fallback();
        test_gaps();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
